vend_change_ctrl: RTL and testbench
===================================

Name: vend_change_ctrl

Overview:
- Credit-tracking vending controller that sits directly upstream of the change-return gate.
- Accumulates coins, validates item selection against parameterised prices, and pulses a dispense strobe.
- Computes change and drives the change-return gate's 4-bit value and enable (change, change_en) for a fixed hold window.
- Handles cancel and refund of the full credit.

Parameters:
- PRICE_A, 5, price of item A in coin units (1..15)
- PRICE_B, 8, price of item B in coin units (1..15)
- CHANGE_HOLD, 4, cycles change_en stays high per return (>=1)
- TIMEOUT_CYCLES, 255, idle cycles before auto-refund (used only with the optional feature)

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- coin_valid  in  1  one-cycle strobe, coin present
- coin_val  in  4  coin value, 1..15; 0 treated as no coin
- sel_valid  in  1  one-cycle strobe, item selected
- sel_item  in  1  0=item A, 1=item B
- cancel  in  1  one-cycle strobe, refund request
- credit  out  4  current accumulated credit
- busy  out  1  high in DISPENSE or RETURN
- coin_reject  out  1  one-cycle pulse, coin not accepted
- insufficient  out  1  one-cycle pulse, selection refused for low credit
- dispense  out  1  one-cycle pulse, release item
- dispense_item  out  1  item being dispensed, valid with dispense
- change  out  4  change value to the return gate; 0 outside RETURN
- change_en  out  1  enable to the return gate

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. While rst_n=0 at a rising edge, state=IDLE and every output is 0, including credit, change and all pulses.
- All outputs are registered.
- States: IDLE (credit=0), COLLECT (credit>0), DISPENSE, RETURN.
- Coin in IDLE/COLLECT:
  - If credit+coin_val<=15, credit updates on the next edge and the state moves to COLLECT.
  - Otherwise coin_reject pulses the next cycle and credit is unchanged. Credit never wraps.
- Coin in DISPENSE/RETURN: always rejected, with coin_reject pulsed.
- Select in COLLECT:
  - If credit>=price(sel_item), the next cycle is DISPENSE. dispense=1 and dispense_item=sel_item for exactly one cycle. The change register is loaded with credit-price.
  - If credit<price, insufficient pulses one cycle and the state stays COLLECT.
- Select in IDLE: insufficient pulses, except when the item's price is 0, which is disallowed by the parameter range.
- DISPENSE → RETURN when change>0; otherwise → IDLE. Either way credit clears to 0.
- RETURN: change_en=1 and change holds its value for exactly CHANGE_HOLD cycles, then the state is IDLE with change=0 and change_en=0.
- Cancel in COLLECT: → RETURN with change=credit, credit=0, no dispense pulse. Cancel in IDLE is ignored.
- Simultaneous events in the same cycle:
  - cancel beats sel_valid beats coin_valid.
  - The losing select produces no insufficient pulse.
  - A losing coin produces coin_reject, so the coin is never silently lost.
- sel_valid and cancel during DISPENSE/RETURN are ignored.
- Reset mid-RETURN aborts immediately: change_en=0 on the next cycle and credit is lost.
- Latency:
  - Coin to credit update: 1 cycle.
  - Select to dispense: 1 cycle.
  - dispense to first change_en: 1 cycle.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- Defined: an idle counter runs in COLLECT. It resets on every accepted or rejected coin and on every select. When it reaches TIMEOUT_CYCLES, it behaves exactly as cancel: → RETURN with change=credit.
- Undefined: no counter is present and credit is held indefinitely.

Decomposition:
- Shared package vend_pkg holds:
  - The state enum (IDLE, COLLECT, DISPENSE, RETURN).
  - Item codes ITEM_A=0 and ITEM_B=1.
  - MONEY_W=4 and CREDIT_MAX=15.
- One natural sub-module is vend_hold_timer, a generic load/decrement counter with a zero flag. It is used for the CHANGE_HOLD window and, under VEND_TIMEOUT_EN, for the timeout.
- The datapath and FSM remain in vend_change_ctrl.

Test Plan:
- Reset, then coins 5 and 5, then select A → credit 5 then 10; dispense with item 0; change=5 with change_en high for 4 cycles; credit=0; state IDLE.
- Credit 10, coin 8 → coin_reject pulse, credit stays 10. Then coin 5 → credit 15 and no reject.
- Credit 4, select B → insufficient pulse, no dispense. Then cancel → change=4 with change_en for 4 cycles and no dispense pulse.
- Credit 8, select B → dispense, change=0, straight to IDLE with change_en never asserted.
- Credit 9: cancel, sel_valid and coin 3 in the same cycle → RETURN with change=9, coin_reject pulses, no insufficient. A coin during RETURN is also rejected.
- rst_n low on the 2nd RETURN cycle → next cycle change_en=0, change=0, credit=0. With VEND_TIMEOUT_EN and TIMEOUT_CYCLES=16, credit 6 left idle → refund of 6 begins after 16 cycles.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending change controller slice.
package vend_pkg;

    localparam int MONEY_W    = 4;
    localparam int CREDIT_MAX = 15;

    localparam logic ITEM_A = 1'b0;
    localparam logic ITEM_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        RETURN   = 2'd3
    } vend_state_e;

    // True when adding a coin keeps the credit representable without wrapping.
    function automatic logic credit_fits(input logic [MONEY_W-1:0] credit,
                                         input logic [MONEY_W-1:0] coin);
        return ({1'b0, credit} + {1'b0, coin}) <= (MONEY_W + 1)'(CREDIT_MAX);
    endfunction

endpackage

// File: rtl/vend_change_ctrl_if.sv
// Coin/selection inputs and dispense/change-return outputs of the vending controller.
interface vend_change_ctrl_if;
    import vend_pkg::*;

    logic               coin_valid;
    logic [MONEY_W-1:0] coin_val;
    logic               sel_valid;
    logic               sel_item;
    logic               cancel;
    logic [MONEY_W-1:0] credit;
    logic               busy;
    logic               coin_reject;
    logic               insufficient;
    logic               dispense;
    logic               dispense_item;
    logic [MONEY_W-1:0] change;
    logic               change_en;

    modport master (
        output coin_valid, coin_val, sel_valid, sel_item, cancel,
        input  credit, busy, coin_reject, insufficient, dispense, dispense_item,
               change, change_en
    );

    modport slave (
        input  coin_valid, coin_val, sel_valid, sel_item, cancel,
        output credit, busy, coin_reject, insufficient, dispense, dispense_item,
               change, change_en
    );

endinterface

// File: rtl/vend_hold_timer.sv
// Generic load/decrement down-counter with a zero flag; load wins over decrement.
module vend_hold_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/vend_change_ctrl.sv
// Credit-tracking vending controller driving the change-return gate.
// Optional idle auto-refund is built when VEND_TIMEOUT_EN is defined.
module vend_change_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE_A        = 5,
    parameter int PRICE_B        = 8,
    parameter int CHANGE_HOLD    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    vend_change_ctrl_if.slave  bus
);

    localparam int HOLD_W = $clog2(CHANGE_HOLD + 1);
    localparam logic [MONEY_W-1:0] PRICE_A_M = MONEY_W'(PRICE_A);
    localparam logic [MONEY_W-1:0] PRICE_B_M = MONEY_W'(PRICE_B);

    if (PRICE_A < 1 || PRICE_A > CREDIT_MAX) begin : g_bad_price_a
        $error("PRICE_A out of range 1..15");
    end
    if (PRICE_B < 1 || PRICE_B > CREDIT_MAX) begin : g_bad_price_b
        $error("PRICE_B out of range 1..15");
    end
    if (CHANGE_HOLD < 1) begin : g_bad_hold
        $error("CHANGE_HOLD must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    vend_state_e        state_reg, state_next;
    logic [MONEY_W-1:0] credit_reg, credit_next;
    logic [MONEY_W-1:0] change_val_reg, change_val_next;
    logic [MONEY_W-1:0] change_reg, change_next;
    logic               change_en_reg, change_en_next;
    logic               busy_reg, busy_next;
    logic               coin_reject_reg, coin_reject_next;
    logic               insufficient_reg, insufficient_next;
    logic               dispense_reg, dispense_next;
    logic               dispense_item_reg, dispense_item_next;

    logic               coin_present;
    logic [MONEY_W-1:0] sel_price;
    logic               hold_load, hold_dec, hold_zero;
    logic               timeout_hit;

    // A zero-valued coin strobe is not a coin at all: neither credited nor rejected.
    assign coin_present = bus.coin_valid && (bus.coin_val != '0);
    assign sel_price    = (bus.sel_item == ITEM_A) ? PRICE_A_M : PRICE_B_M;

    vend_hold_timer #(.W(HOLD_W)) u_hold_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (hold_load),
        .dec      (hold_dec),
        .load_val (HOLD_W'(CHANGE_HOLD - 1)),
        .zero     (hold_zero)
    );

`ifdef VEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic idle_load, idle_zero;

    // Any coin or select restarts the idle window; outside COLLECT it is kept armed.
    assign idle_load = (state_reg != COLLECT) || coin_present || bus.sel_valid;

    vend_hold_timer #(.W(TO_W)) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (idle_load),
        .dec      (!idle_load),
        .load_val (TO_W'(TIMEOUT_CYCLES - 1)),
        .zero     (idle_zero)
    );

    assign timeout_hit = (state_reg == COLLECT) && !idle_load && idle_zero;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            credit_reg        <= '0;
            change_val_reg    <= '0;
            change_reg        <= '0;
            change_en_reg     <= 1'b0;
            busy_reg          <= 1'b0;
            coin_reject_reg   <= 1'b0;
            insufficient_reg  <= 1'b0;
            dispense_reg      <= 1'b0;
            dispense_item_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            credit_reg        <= credit_next;
            change_val_reg    <= change_val_next;
            change_reg        <= change_next;
            change_en_reg     <= change_en_next;
            busy_reg          <= busy_next;
            coin_reject_reg   <= coin_reject_next;
            insufficient_reg  <= insufficient_next;
            dispense_reg      <= dispense_next;
            dispense_item_reg <= dispense_item_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        credit_next        = credit_reg;
        change_val_next    = change_val_reg;
        coin_reject_next   = 1'b0;
        insufficient_next  = 1'b0;
        dispense_next      = 1'b0;
        dispense_item_next = 1'b0;
        hold_load          = 1'b0;
        hold_dec           = 1'b0;

        unique case (state_reg)
            IDLE, COLLECT: begin
                // Priority: cancel/timeout, then select, then coin; a losing coin is rejected.
                if ((state_reg == COLLECT) && (bus.cancel || timeout_hit)) begin
                    state_next       = RETURN;
                    change_val_next  = credit_reg;
                    credit_next      = '0;
                    hold_load        = 1'b1;
                    coin_reject_next = coin_present;
                end else if (bus.sel_valid) begin
                    coin_reject_next = coin_present;
                    if (credit_reg >= sel_price) begin
                        state_next         = DISPENSE;
                        dispense_next      = 1'b1;
                        dispense_item_next = bus.sel_item;
                        change_val_next    = credit_reg - sel_price;
                    end else begin
                        insufficient_next = 1'b1;
                    end
                end else if (coin_present) begin
                    if (credit_fits(credit_reg, bus.coin_val)) begin
                        credit_next = credit_reg + bus.coin_val;
                        state_next  = COLLECT;
                    end else begin
                        coin_reject_next = 1'b1;
                    end
                end
            end
            DISPENSE: begin
                coin_reject_next = coin_present;
                credit_next      = '0;
                if (change_val_reg != '0) begin
                    state_next = RETURN;
                    hold_load  = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            RETURN: begin
                coin_reject_next = coin_present;
                if (hold_zero) begin
                    state_next      = IDLE;
                    change_val_next = '0;
                end else begin
                    hold_dec = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Gate-facing outputs follow the next state so they are registered with it.
    always_comb begin
        change_en_next = (state_next == RETURN);
        change_next    = (state_next == RETURN) ? change_val_next : '0;
        busy_next      = (state_next == DISPENSE) || (state_next == RETURN);
    end

    assign bus.credit        = credit_reg;
    assign bus.busy          = busy_reg;
    assign bus.coin_reject   = coin_reject_reg;
    assign bus.insufficient  = insufficient_reg;
    assign bus.dispense      = dispense_reg;
    assign bus.dispense_item = dispense_item_reg;
    assign bus.change        = change_reg;
    assign bus.change_en     = change_en_reg;

endmodule

// File: tb/tb_vend_change_ctrl.sv
// Self-checking bench for vend_change_ctrl: vector table plus hand-written sequences.
module tb_vend_change_ctrl;
    import vend_pkg::*;

    typedef struct packed {
        logic       rst_n;
        logic       coin_valid;
        logic [3:0] coin_val;
        logic       sel_valid;
        logic       sel_item;
        logic       cancel;
    } ins_t;

    typedef struct packed {
        logic [3:0] credit;
        logic       busy;
        logic       coin_reject;
        logic       insufficient;
        logic       dispense;
        logic       dispense_item;
        logic [3:0] change;
        logic       change_en;
    } outs_t;

    typedef struct packed {
        ins_t  in;
        outs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vend_change_ctrl_if bus();

    vend_change_ctrl #(
        .PRICE_A        (5),
        .PRICE_B        (8),
        .CHANGE_HOLD    (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vec_t  vecs[$];
    outs_t sb[$];
    int    tests = 0;
    int    fails = 0;

    task automatic row(input logic r, input logic cv, input logic [3:0] cval,
                       input logic sv, input logic si, input logic cn,
                       input logic [3:0] cr, input logic bz, input logic rj,
                       input logic nf, input logic dp, input logic it,
                       input logic [3:0] ch, input logic ce);
        vec_t v;
        v.in  = '{r, cv, cval, sv, si, cn};
        v.exp = '{cr, bz, rj, nf, dp, it, ch, ce};
        vecs.push_back(v);
    endtask

    task automatic drive(input ins_t i);
        rst_n          = i.rst_n;
        bus.coin_valid = i.coin_valid;
        bus.coin_val   = i.coin_val;
        bus.sel_valid  = i.sel_valid;
        bus.sel_item   = i.sel_item;
        bus.cancel     = i.cancel;
    endtask

    function automatic outs_t sample();
        outs_t o;
        o.credit        = bus.credit;
        o.busy          = bus.busy;
        o.coin_reject   = bus.coin_reject;
        o.insufficient  = bus.insufficient;
        o.dispense      = bus.dispense;
        o.dispense_item = bus.dispense_item;
        o.change        = bus.change;
        o.change_en     = bus.change_en;
        return o;
    endfunction

    task automatic check(input string name);
        outs_t a, e;
        a = sample();
        e = sb.pop_front();
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: actual credit=%0d busy=%b rej=%b insuf=%b disp=%b item=%b change=%0d en=%b | required credit=%0d busy=%b rej=%b insuf=%b disp=%b item=%b change=%0d en=%b",
                     name, a.credit, a.busy, a.coin_reject, a.insufficient, a.dispense,
                     a.dispense_item, a.change, a.change_en, e.credit, e.busy, e.coin_reject,
                     e.insufficient, e.dispense, e.dispense_item, e.change, e.change_en);
        end else begin
            $display("[TB] ok %s: credit=%0d busy=%b rej=%b insuf=%b disp=%b item=%b change=%0d en=%b",
                     name, a.credit, a.busy, a.coin_reject, a.insufficient, a.dispense,
                     a.dispense_item, a.change, a.change_en);
        end
    endtask

    // Drive one cycle of inputs, queue what the DUT must show after the edge, then compare.
    task automatic step(input ins_t i, input outs_t e, input string name);
        drive(i);
        sb.push_back(e);
        @(posedge clk);
        #1;
        check(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t  idle_in;
        int    model;
        int    hold_cnt;
        bit    ended;

        idle_in = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        drive('{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0});

        // Reset, two coins of 5, buy A, 5 back over a 4-cycle window.
        row(0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        row(0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        row(1,1,5,0,0,0, 5,0,0,0,0,0,0,0);
        row(1,1,5,0,0,0, 10,0,0,0,0,0,0,0);
        row(1,0,0,1,0,0, 10,1,0,0,1,0,0,0);
        for (int k = 0; k < 4; k++) row(1,0,0,0,0,0, 0,1,0,0,0,0,5,1);
        row(1,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        // Overflow rejection and the exact-15 ceiling.
        row(1,1,10,0,0,0, 10,0,0,0,0,0,0,0);
        row(1,1,8,0,0,0,  10,0,1,0,0,0,0,0);
        row(1,1,5,0,0,0,  15,0,0,0,0,0,0,0);
        row(1,1,1,0,0,0,  15,0,1,0,0,0,0,0);
        row(1,0,0,0,0,1,  0,1,0,0,0,0,15,1);
        for (int k = 0; k < 3; k++) row(1,0,0,0,0,0, 0,1,0,0,0,0,15,1);
        row(1,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        // Insufficient credit for B, then cancel refund.
        row(1,1,4,0,0,0, 4,0,0,0,0,0,0,0);
        row(1,0,0,1,1,0, 4,0,0,1,0,0,0,0);
        row(1,0,0,0,0,1, 0,1,0,0,0,0,4,1);
        for (int k = 0; k < 3; k++) row(1,0,0,0,0,0, 0,1,0,0,0,0,4,1);
        row(1,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        // Exact price of B: no change, straight back to IDLE.
        row(1,1,8,0,0,0, 8,0,0,0,0,0,0,0);
        row(1,0,0,1,1,0, 8,1,0,0,1,1,0,0);
        row(1,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        row(1,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        // Cancel + select + coin together; coin and select during RETURN.
        row(1,1,9,0,0,0, 9,0,0,0,0,0,0,0);
        row(1,1,3,1,0,1, 0,1,1,0,0,0,9,1);
        row(1,1,2,0,0,0, 0,1,1,0,0,0,9,1);
        row(1,0,0,1,0,0, 0,1,0,0,0,0,9,1);
        row(1,0,0,0,0,0, 0,1,0,0,0,0,9,1);
        row(1,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        // Reset during the second RETURN cycle.
        row(1,1,7,0,0,0, 7,0,0,0,0,0,0,0);
        row(1,0,0,0,0,1, 0,1,0,0,0,0,7,1);
        row(1,0,0,0,0,0, 0,1,0,0,0,0,7,1);
        row(0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        row(1,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        // Zero-valued coin, select in IDLE, select+coin in COLLECT, exact price A.
        row(1,1,0,0,0,0, 0,0,0,0,0,0,0,0);
        row(1,0,0,1,0,0, 0,0,0,1,0,0,0,0);
        row(1,1,3,0,0,0, 3,0,0,0,0,0,0,0);
        row(1,1,2,1,0,0, 3,0,1,1,0,0,0,0);
        row(1,1,2,0,0,0, 5,0,0,0,0,0,0,0);
        row(1,0,0,1,0,0, 5,1,0,0,1,0,0,0);
        row(1,0,0,0,0,0, 0,0,0,0,0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].in, vecs[i].exp, $sformatf("row%0d", i));
        end

`ifdef VEND_TIMEOUT_EN
        // Credit 6 left idle for 16 cycles is refunded automatically.
        step('{1'b1, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0}, '{4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0}, "to_coin");
        for (int k = 0; k < 15; k++) begin
            step(idle_in, '{4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0}, $sformatf("to_wait%0d", k));
        end
        step(idle_in, '{4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 1'b1}, "to_refund");
        for (int k = 0; k < 3; k++) begin
            step(idle_in, '{4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 1'b1}, $sformatf("to_hold%0d", k));
        end
        step(idle_in, '0, "to_idle");
`endif

        // Random coins against a credit model, then a cancel whose window is measured.
        model = 0;
        for (int k = 0; k < 20; k++) begin
            int   v;
            logic rej;
            outs_t e;
            v = $urandom_range(1, 15);
            if (model + v <= CREDIT_MAX) begin
                model = model + v;
                rej   = 1'b0;
            end else begin
                rej = 1'b1;
            end
            e = '{4'(model), 1'b0, rej, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
            step('{1'b1, 1'b1, 4'(v), 1'b0, 1'b0, 1'b0}, e, $sformatf("rand_coin%0d_v%0d", k, v));
        end
        step('{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1},
             '{4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'(model), 1'b1}, "rand_cancel");

        hold_cnt = 1;
        ended    = 1'b0;
        drive(idle_in);
        for (int k = 0; k < 20 && !ended; k++) begin
            @(posedge clk);
            #1;
            if (bus.change_en === 1'b1) hold_cnt++;
            else ended = 1'b1;
        end
        tests++;
        if (!ended || hold_cnt != 4) begin
            fails++;
            $display("FAIL hold_window: actual %0d cycles (ended=%0b), required 4", hold_cnt, ended);
        end else begin
            $display("[TB] ok hold_window: change_en high for %0d cycles", hold_cnt);
        end
        sb.push_back('0);
        check("hold_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
